rotary_input_emu: RTL
=====================

Name: rotary_input_emu

Overview:
- Converts digital rotate requests (buttons, or pulses from the analog spinner on joystick bits 30/31) into a free-running 8-bit rotary angle.
- Sits directly upstream of the MCR2 input mux. Its angle drives the spinner input ports (input_1 / input_4, bits [7:1]) for Tron, Two Tigers and Kroozr.
- Button mode ramps the step size once per video frame (acceleration). Spinner mode counts discrete pulses.
- Replaces the fixed-rate spinner path and adds acceleration, direction-reversal handling and a motion flag.

Parameters:
- STEP_MAX, 55: maximum per-frame step in button mode, 1..127.
- STEP_START, 1: step applied on the first frame a button is held, 1..STEP_MAX.
- ACCEL, 1: step increment per held frame.
- ANGLE_W, 8: angle width. The counter wraps modulo 2^ANGLE_W.

Ports:
- clk  in  1  system clock (40 MHz).
- reset  in  1  synchronous, active-high reset.
- minus  in  1  rotate counter-clockwise request (level in button mode, pulse source in spinner mode).
- plus  in  1  rotate clockwise request (level or pulse source).
- strobe  in  1  frame strobe (VSYNC); only its rising edge is used.
- use_spinner  in  1  1 = spinner pulse mode, 0 = button mode.
- spin_angle  out  ANGLE_W  current angle.
- moving  out  1  high for the frame following any nonzero angle change.
- step_dbg  out  7  current button-mode step, for debug and verification.

Behaviour:
- Reset (synchronous, active-high):
  - spin_angle=0, moving=0, step_dbg=STEP_START.
  - All edge-detect history registers=0.
  - Reset overrides every other event in the same cycle.
- Edge detection:
  - strobe, plus and minus are each registered once.
  - A rising edge is the current sample high while the previous sample was low.
  - Inputs are assumed synchronous to clk; no synchronizer is included.
- Spinner mode (use_spinner=1):
  - Rising edge of plus: angle+1. Rising edge of minus: angle-1.
  - Both edges in the same cycle: no change.
  - Strobe is ignored for angle updates.
  - step is held at STEP_START.
  - Latency: angle valid on the cycle after the edge-detect cycle, i.e. 2 clocks after the input rises.
- Button mode (use_spinner=0) is a state machine with states IDLE, CW and CCW, evaluated only on a strobe rising edge:
  - Only plus held: from IDLE or CCW go to CW with step=STEP_START. From CW, step=min(step+ACCEL, STEP_MAX). Then angle += step.
  - Only minus held: symmetric with CCW; angle -= step.
  - Neither held, or both held: go to IDLE, step=STEP_START, angle unchanged.
  - Direction reversal (CW to CCW or back) resets step to STEP_START on that same frame.
  - Saturation arithmetic is done on ACCEL+STEP_MAX in an 8-bit intermediate, so no overflow occurs.
- Mode switch: any change of use_spinner forces IDLE and step=STEP_START in the next cycle. The angle is preserved and does not jump.
- Wrap-around: the angle counter is modular, so 255+1=0 and 0-1=255. No saturation of the angle.
- moving:
  - Set in the cycle the angle changes.
  - Cleared on the next strobe rising edge that produces no change.
  - In spinner mode it is cleared on any strobe edge with no pulse since the previous strobe.

Decomposition:
- Shared package mcr_input_pkg:
  - ANGLE_W_DEF=8.
  - Enum rot_state_t {ROT_IDLE, ROT_CW, ROT_CCW}.
  - Function sat_add7(step, accel, max).
- One sub-module, edge_rise:
  - Parameterised-width register plus rising-edge detect.
  - Instantiated once with width 3 for {strobe, plus, minus}.

Test Plan:
- Button mode, defaults, reset then hold plus across 3 strobe edges -> angle 1, 3, 6; step_dbg 1, 2, 3.
- Button mode, hold minus from 0 across 3 strobe edges -> angle 255, 253, 250 (wrap); then release with 1 strobe -> angle 250, step_dbg=1, moving=0.
- Button mode, STEP_MAX=4, hold plus for 6 strobes -> angle 1, 3, 6, 10, 14, 18; step_dbg saturates at 4.
- Reversal: hold plus for 2 strobes (angle 3), then minus for 1 strobe -> angle 2, step_dbg=1. Plus and minus both held -> angle unchanged, state IDLE.
- Spinner mode: 5 plus pulses (2 clocks high, 10 low) then 2 minus pulses -> angle 3; strobe edges in between cause no change. Simultaneous plus and minus edge -> no change.
- Reset asserted mid-hold at angle 6, step 3 -> next cycle angle=0, step_dbg=1, moving=0. After release, the next strobe with plus held -> angle 1.

Source files
------------

// File: rtl/mcr_input_pkg.sv
// -----------------------------------------------------------------------------
// mcr_input_pkg
// Shared definitions for the MCR2 rotary input path.
//   ANGLE_W_DEF  : default rotary angle width
//   rot_state_t  : button-mode rotation state (IDLE / CW / CCW)
//   sat_add7     : 7-bit step increment that saturates at a ceiling
// -----------------------------------------------------------------------------
package mcr_input_pkg;

    localparam int ANGLE_W_DEF = 8;

    typedef enum logic [1:0] {
        ROT_IDLE = 2'd0,
        ROT_CW   = 2'd1,
        ROT_CCW  = 2'd2
    } rot_state_t;

    // The sum is formed one bit wider than the operands, so step+accel can
    // never wrap before it is compared against the ceiling.
    function automatic logic [6:0] sat_add7(
        input logic [6:0] step,
        input logic [6:0] accel,
        input logic [6:0] step_max
    );
        logic [7:0] sum;
        sum = {1'b0, step} + {1'b0, accel};
        if (sum > {1'b0, step_max}) begin
            return step_max;
        end
        return sum[6:0];
    endfunction

endpackage

// File: rtl/edge_rise.sv
// -----------------------------------------------------------------------------
// edge_rise
// Registers a W-bit bus twice and flags the bits whose registered sample is
// high while the previous sample was low.
//   clk, reset : clock and synchronous active-high reset (history cleared)
//   i_d        : synchronous input bus
//   o_rise     : one-cycle rising-edge flags, one per bit
// -----------------------------------------------------------------------------
module edge_rise #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_cur;
    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= '0;
            r_prev <= '0;
        end else begin
            r_cur  <= i_d;
            r_prev <= r_cur;
        end
    end

    assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/rotary_input_emu.sv
// -----------------------------------------------------------------------------
// rotary_input_emu
// Turns rotate requests into a free-running rotary angle for the MCR2 spinner
// inputs. Button mode accelerates the per-frame step while a direction is
// held; spinner mode counts discrete plus/minus pulses.
//   clk, reset   : system clock, synchronous active-high reset
//   minus, plus  : rotate CCW / CW (held level or pulse source)
//   strobe       : frame strobe, rising edge marks a new frame
//   use_spinner  : 1 = pulse counting, 0 = accelerated buttons
//   spin_angle   : current angle, wraps modulo 2^ANGLE_W
//   moving       : angle changed since the last quiet frame
//   step_dbg     : current button-mode step
//   state_dbg    : button-mode FSM state (rot_state_t encoding)
// -----------------------------------------------------------------------------
module rotary_input_emu
    import mcr_input_pkg::*;
#(
    parameter int STEP_MAX   = 55,
    parameter int STEP_START = 1,
    parameter int ACCEL      = 1,
    parameter int ANGLE_W    = ANGLE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               minus,
    input  logic               plus,
    input  logic               strobe,
    input  logic               use_spinner,
    output logic [ANGLE_W-1:0] spin_angle,
    output logic               moving,
    output logic [6:0]         step_dbg,
    output logic [1:0]         state_dbg
);

    localparam logic [6:0]         LP_STEP_MAX   = 7'(STEP_MAX);
    localparam logic [6:0]         LP_STEP_START = 7'(STEP_START);
    localparam logic [6:0]         LP_ACCEL      = 7'(ACCEL);
    localparam logic [ANGLE_W-1:0] LP_ONE        = ANGLE_W'(1);

    // Edge detect for {strobe, plus, minus}
    logic [2:0] w_rise;
    logic       w_strobe_rise;
    logic       w_plus_rise;
    logic       w_minus_rise;

    edge_rise #(.W(3)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .i_d    ({strobe, plus, minus}),
        .o_rise (w_rise)
    );

    assign w_strobe_rise = w_rise[2];
    assign w_plus_rise   = w_rise[1];
    assign w_minus_rise  = w_rise[0];

    rot_state_t         r_state;
    logic [6:0]         r_step;
    logic [ANGLE_W-1:0] r_angle;
    logic               r_moving;
    logic               r_seen;       // spinner pulse since the last strobe
    logic               r_mode_prev;

    rot_state_t         w_state_nxt;
    logic [6:0]         w_step_nxt;
    logic [ANGLE_W-1:0] w_angle_nxt;
    logic               w_moving_nxt;
    logic               w_seen_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ROT_IDLE;
            r_step      <= LP_STEP_START;
            r_angle     <= '0;
            r_moving    <= 1'b0;
            r_seen      <= 1'b0;
            // Track the current mode so leaving reset is not seen as a switch.
            r_mode_prev <= use_spinner;
        end else begin
            r_state     <= w_state_nxt;
            r_step      <= w_step_nxt;
            r_angle     <= w_angle_nxt;
            r_moving    <= w_moving_nxt;
            r_seen      <= w_seen_nxt;
            r_mode_prev <= use_spinner;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_angle_nxt  = r_angle;
        w_moving_nxt = r_moving;
        w_seen_nxt   = r_seen;

        if (use_spinner != r_mode_prev) begin
            // Mode change: restart the button machine, keep the angle.
            w_state_nxt = ROT_IDLE;
            w_step_nxt  = LP_STEP_START;
        end else if (use_spinner) begin
            w_state_nxt = ROT_IDLE;
            w_step_nxt  = LP_STEP_START;
            if (w_strobe_rise) begin
                if (!r_seen) begin
                    w_moving_nxt = 1'b0;
                end
                w_seen_nxt = 1'b0;
            end
            // Simultaneous plus and minus edges cancel.
            if (w_plus_rise && !w_minus_rise) begin
                w_angle_nxt  = r_angle + LP_ONE;
                w_moving_nxt = 1'b1;
                w_seen_nxt   = 1'b1;
            end else if (w_minus_rise && !w_plus_rise) begin
                w_angle_nxt  = r_angle - LP_ONE;
                w_moving_nxt = 1'b1;
                w_seen_nxt   = 1'b1;
            end
        end else if (w_strobe_rise) begin
            case ({plus, minus})
                2'b10: begin
                    w_step_nxt   = (r_state == ROT_CW) ?
                                   sat_add7(r_step, LP_ACCEL, LP_STEP_MAX) :
                                   LP_STEP_START;
                    w_state_nxt  = ROT_CW;
                    w_angle_nxt  = r_angle + ANGLE_W'(w_step_nxt);
                    w_moving_nxt = 1'b1;
                end
                2'b01: begin
                    w_step_nxt   = (r_state == ROT_CCW) ?
                                   sat_add7(r_step, LP_ACCEL, LP_STEP_MAX) :
                                   LP_STEP_START;
                    w_state_nxt  = ROT_CCW;
                    w_angle_nxt  = r_angle - ANGLE_W'(w_step_nxt);
                    w_moving_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt  = ROT_IDLE;
                    w_step_nxt   = LP_STEP_START;
                    w_moving_nxt = 1'b0;
                end
            endcase
        end
    end

    assign spin_angle = r_angle;
    assign moving     = r_moving;
    assign step_dbg   = r_step;
    assign state_dbg  = r_state;

endmodule
